pulse_sequencer: RTL and testbench

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_seq_pkg.sv | 28 ++
 rtl/pulse_seq_table.sv | 36 +++
 rtl/pulse_sequencer.sv | 157 +++++++++++++++
 tb/tb_pulse_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared types for the pulse sequencer (state encoding, profile entry).
// Revision 1.0
`default_nettype none

package pulse_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [31:0] delay;
    logic [31:0] width;
    logic [9:0]  rep;
  } pulse_entry_t;

  // The generator's down-counters wrap when loaded with zero.
  function automatic logic entry_launchable(input pulse_entry_t e);
    return (e.delay != 32'd0) && (e.width != 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_seq_table.sv
// pulse_seq_table: profile storage, synchronous write, combinational read, cleared on reset.
// Revision 1.0
`default_nettype none

module pulse_seq_table
  import pulse_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  pulse_entry_t       wdata,
  input  logic [IDX_W-1:0]   raddr,
  output pulse_entry_t       rdata
);

  pulse_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: steps a pulse generator through a table of profiles.
// Optional looping over the sequence is compiled in with PULSE_SEQ_LOOP_EN. Revision 1.0
`default_nettype none

module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [31:0]      cfg_delay,
  input  logic [31:0]      cfg_width,
  input  logic [9:0]       cfg_rep,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             go,
  input  logic             abort,
`ifdef PULSE_SEQ_LOOP_EN
  input  logic             loop,
`endif
  input  logic             gen_busy,
  output logic             gen_start,
  output logic [31:0]      gen_delay_cycles,
  output logic [31:0]      gen_pulse_width_cycles,
  output logic [9:0]       gen_repetition,
  output logic             gen_clear,
  output logic             busy,
  output logic [IDX_W-1:0] cur_idx,
  output logic             done,
  output logic             err
);

  seq_state_t       state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] last_q, last_n;
  logic             err_n;
  logic             wb_cnt, wb_n;
  logic             start_c, clear_c, done_c;
  pulse_entry_t     wr_entry, entry;

  assign wr_entry = '{delay: cfg_delay, width: cfg_width, rep: cfg_rep};

  // Writes are only accepted in IDLE so the active profile cannot change under the generator.
  pulse_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we && (state == IDLE)),
    .waddr (cfg_addr),
    .wdata (wr_entry),
    .raddr (cur_idx),
    .rdata (entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cur_idx <= '0;
      last_q  <= '0;
      err     <= 1'b0;
      wb_cnt  <= 1'b0;
    end else begin
      state   <= state_n;
      cur_idx <= idx_n;
      last_q  <= last_n;
      err     <= err_n;
      wb_cnt  <= wb_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    last_n  = last_q;
    err_n   = err;
    wb_n    = wb_cnt;
    start_c = 1'b0;
    clear_c = 1'b0;
    done_c  = 1'b0;
    if ((state != IDLE) && abort) begin
      clear_c = 1'b1;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go && !abort) begin
            err_n   = 1'b0;
            idx_n   = '0;
            last_n  = last_idx;
            state_n = LAUNCH;
          end
        end
        LAUNCH: begin
          if (entry_launchable(entry)) begin
            start_c = 1'b1;
            wb_n    = 1'b0;
            state_n = WAIT_BUSY;
          end else begin
            err_n   = 1'b1;
            clear_c = 1'b1;
            state_n = IDLE;
          end
        end
        WAIT_BUSY: begin
          if (gen_busy) begin
            state_n = WAIT_DONE;
          end else if (wb_cnt) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            wb_n = 1'b1;
          end
        end
        WAIT_DONE: begin
          // rep == 0 runs forever, so only abort or reset can leave.
          if (!gen_busy && (entry.rep != 10'd0)) begin
            state_n = NEXT;
          end
        end
        NEXT: begin
          if (cur_idx != last_q) begin
            idx_n   = cur_idx + 1'b1;
            state_n = LAUNCH;
          end
`ifdef PULSE_SEQ_LOOP_EN
          else if (loop) begin
            idx_n   = '0;
            done_c  = 1'b1;
            state_n = LAUNCH;
          end
`endif
          else begin
            done_c  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign gen_start = start_c && !reset;
  assign gen_clear = clear_c && !reset;
  assign done      = done_c && !reset;
  assign busy      = (state != IDLE);

  assign gen_delay_cycles       = busy ? entry.delay : 32'd0;
  assign gen_pulse_width_cycles = busy ? entry.width : 32'd0;
  assign gen_repetition         = busy ? entry.rep : 10'd0;

endmodule

`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: directed bench with a generator model and a launch scoreboard.
// Revision 1.0
`default_nettype none

`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_pulse_sequencer;

  localparam int DEPTH = 4;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic [31:0] w;
    logic [9:0]  r;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [31:0]      cfg_delay = '0;
  logic [31:0]      cfg_width = '0;
  logic [9:0]       cfg_rep = '0;
  logic [IDX_W-1:0] last_idx = '0;
  logic             go = 1'b0;
  logic             abort = 1'b0;
  logic             loop = 1'b0;
  logic             gen_busy = 1'b0;
  logic             gen_start, gen_clear, busy, done, err;
  logic [31:0]      gen_delay_cycles, gen_pulse_width_cycles;
  logic [9:0]       gen_repetition;
  logic [IDX_W-1:0] cur_idx;

  pulse_sequencer #(.DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cfg_we                 (cfg_we),
    .cfg_addr               (cfg_addr),
    .cfg_delay              (cfg_delay),
    .cfg_width              (cfg_width),
    .cfg_rep                (cfg_rep),
    .last_idx               (last_idx),
    .go                     (go),
    .abort                  (abort),
`ifdef PULSE_SEQ_LOOP_EN
    .loop                   (loop),
`endif
    .gen_busy               (gen_busy),
    .gen_start              (gen_start),
    .gen_delay_cycles       (gen_delay_cycles),
    .gen_pulse_width_cycles (gen_pulse_width_cycles),
    .gen_repetition         (gen_repetition),
    .gen_clear              (gen_clear),
    .busy                   (busy),
    .cur_idx                (cur_idx),
    .done                   (done),
    .err                    (err)
  );

  initial forever #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   starts = 0, clears = 0, dones = 0, last_done_cyc = 0;
  int   start_log[$];
  exp_t sb[$];
  exp_t mon_e;
  int   rem = 0;
  bit   inf = 1'b0;
  bit   stuck = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Generator model drives gen_busy at +2; all outputs are sampled at +4.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      gen_busy = inf || (rem > 0);
      if (rem > 0) rem--;
      #2;
      if (gen_start === 1'b1) begin
        starts++;
        start_log.push_back(cyc);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $error("FAIL start_expected: observed 0 expected 1");
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          vectors++;
          if (64'(cur_idx) !== 64'(mon_e.idx)) begin
            miscompares++;
            $error("FAIL launch_idx: observed %0h expected %0h", cur_idx, mon_e.idx);
          end
          vectors++;
          if (gen_delay_cycles !== mon_e.d) begin
            miscompares++;
            $error("FAIL launch_delay: observed %0h expected %0h", gen_delay_cycles, mon_e.d);
          end
          vectors++;
          if (gen_pulse_width_cycles !== mon_e.w) begin
            miscompares++;
            $error("FAIL launch_width: observed %0h expected %0h", gen_pulse_width_cycles, mon_e.w);
          end
          vectors++;
          if (gen_repetition !== mon_e.r) begin
            miscompares++;
            $error("FAIL launch_rep: observed %0h expected %0h", gen_repetition, mon_e.r);
          end
        end
        if (!stuck) begin
          rem = int'(gen_delay_cycles + gen_pulse_width_cycles) * int'(gen_repetition);
          inf = (gen_repetition == 10'd0);
        end
      end
      if (gen_clear === 1'b1) begin
        clears++;
        rem = 0;
        inf = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic cfg_write(input int a, input int d, input int w, input int r);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(a);
    cfg_delay = 32'(d);
    cfg_width = 32'(w);
    cfg_rep   = 10'(r);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic expect_launch(input int i, input int d, input int w, input int r);
    exp_t e;
    e.idx = i;
    e.d   = 32'(d);
    e.w   = 32'(w);
    e.r   = 10'(r);
    sb.push_back(e);
  endtask

  task automatic pulse_go(output int gc);
    go = 1'b1;
    gc = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_dones(input int target);
    for (int i = 0; i < 600 && dones < target; i++) tick();
  endtask

  int gc, bd, bc, bs;

  initial begin
    // Reset values
    repeat (3) tick();
    peek();
    `CHK("rst_gen_start", gen_start, 0);
    `CHK("rst_gen_clear", gen_clear, 0);
    `CHK("rst_busy", busy, 0);
    `CHK("rst_done", done, 0);
    `CHK("rst_err", err, 0);
    `CHK("rst_cur_idx", cur_idx, 0);
    `CHK("rst_delay", gen_delay_cycles, 0);
    `CHK("rst_width", gen_pulse_width_cycles, 0);
    `CHK("rst_rep", gen_repetition, 0);
    tick();
    reset = 1'b0;
    tick();

    // Cleared table: entry 0 is all zero, so go must error out
    bs = starts; bc = clears;
    pulse_go(gc);
    tick();
    peek();
    `CHK("clr_err", err, 1);
    `CHK("clr_busy", busy, 0);
    `CHK("clr_gen_clear_count", clears - bc, 1);
    `CHK("clr_no_start", starts - bs, 0);
    tick();

    // Two-entry sequence; last_idx changed after go must be ignored
    cfg_write(0, 5, 3, 1);
    cfg_write(1, 2, 2, 2);
    last_idx = 1;
    expect_launch(0, 5, 3, 1);
    expect_launch(1, 2, 2, 2);
    start_log.delete();
    bd = dones;
    pulse_go(gc);
    last_idx = 0;
    wait_dones(bd + 1);
    tick();
    peek();
    `CHK("seq_launch_lat", start_log.size() > 0 ? start_log[0] - gc : -1, 1);
    `CHK("seq_start_count", start_log.size(), 2);
    `CHK("seq_gap", start_log.size() == 2 ? start_log[1] - start_log[0] : -1, 11);
    `CHK("seq_done_lat", start_log.size() == 2 ? last_done_cyc - start_log[1] : -1, 10);
    `CHK("seq_done_count", dones - bd, 1);
    `CHK("seq_busy", busy, 0);
    `CHK("seq_err", err, 0);
    `CHK("seq_sb_empty", sb.size(), 0);
    tick();

    // Zero width entry
    cfg_write(0, 4, 0, 1);
    last_idx = 0;
    bs = starts; bc = clears;
    pulse_go(gc);
    tick();
    peek();
    `CHK("zw_err", err, 1);
    `CHK("zw_busy", busy, 0);
    `CHK("zw_gen_clear_count", clears - bc, 1);
    `CHK("zw_no_start", starts - bs, 0);
    tick();

    // Generator never reports busy
    stuck = 1'b1;
    cfg_write(0, 3, 3, 1);
    expect_launch(0, 3, 3, 1);
    pulse_go(gc);
    peek();
    `CHK("to_start", gen_start, 1);
    `CHK("to_err_cleared", err, 0);
    tick();
    tick();
    peek();
    `CHK("to_err_early", err, 0);
    `CHK("to_busy_early", busy, 1);
    tick();
    peek();
    `CHK("to_err", err, 1);
    `CHK("to_busy", busy, 0);
    stuck = 1'b0;
    tick();

    // Infinite repetition, then abort
    cfg_write(0, 2, 3, 0);
    expect_launch(0, 2, 3, 0);
    bd = dones; bc = clears;
    pulse_go(gc);
    repeat (100) tick();
    peek();
    `CHK("inf_busy", busy, 1);
    `CHK("inf_idx", cur_idx, 0);
    `CHK("inf_no_done", dones - bd, 0);
    tick();
    abort = 1'b1;
    peek();
    `CHK("ab_gen_clear", gen_clear, 1);
    tick();
    abort = 1'b0;
    peek();
    `CHK("ab_busy", busy, 0);
    tick();
    `CHK("ab_clear_count", clears - bc, 1);
    `CHK("ab_no_done", dones - bd, 0);
    `CHK("ab_err", err, 0);

    // go and abort together in IDLE
    bs = starts;
    go = 1'b1;
    abort = 1'b1;
    tick();
    go = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    peek();
    `CHK("ga_busy", busy, 0);
    `CHK("ga_no_start", starts - bs, 0);
    tick();

    // Write and go while busy are dropped; readback shows the original entry
    cfg_write(0, 7, 7, 1);
    last_idx = 0;
    expect_launch(0, 7, 7, 1);
    bd = dones; bs = starts;
    pulse_go(gc);
    tick();
    cfg_we = 1'b1; cfg_addr = '0; cfg_delay = 32'd9; cfg_width = 32'd9; cfg_rep = 10'd9;
    tick();
    cfg_we = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_dones(bd + 1);
    tick();
    expect_launch(0, 7, 7, 1);
    pulse_go(gc);
    wait_dones(bd + 2);
    tick();
    `CHK("wb_done_count", dones - bd, 2);
    `CHK("wb_start_count", starts - bs, 2);
    `CHK("wb_sb_empty", sb.size(), 0);

`ifdef PULSE_SEQ_LOOP_EN
    // Looping: 0,1,0,1 then stop after the second pass
    cfg_write(0, 2, 1, 1);
    cfg_write(1, 1, 2, 1);
    last_idx = 1;
    loop = 1'b1;
    expect_launch(0, 2, 1, 1);
    expect_launch(1, 1, 2, 1);
    expect_launch(0, 2, 1, 1);
    expect_launch(1, 1, 2, 1);
    start_log.delete();
    bd = dones;
    pulse_go(gc);
    for (int i = 0; i < 400 && start_log.size() < 4; i++) tick();
    `CHK("lp_done_first_pass", dones - bd, 1);
    loop = 1'b0;
    wait_dones(bd + 2);
    tick();
    peek();
    `CHK("lp_start_count", start_log.size(), 4);
    `CHK("lp_done_count", dones - bd, 2);
    `CHK("lp_busy", busy, 0);
    `CHK("lp_sb_empty", sb.size(), 0);
`endif

    repeat (3) tick();
    `CHK("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
